// File: rtl/stp_pkg.sv
// Shared defaults, state enums and helpers for the stp frame buffer.
// The optional STP_BITREV_EN build relies on is_pow2() to reject illegal depths.
package stp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 48;

    typedef enum logic {
        IN_FILL,
        IN_LAST
    } in_state_e;

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/stp_index_map.sv
// Maps a write index k to its slot in the parallel frame.
// Identity by default; bit-reversed (FFT input order) when STP_BITREV_EN is defined.
module stp_index_map
    import stp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] slot
);

`ifdef STP_BITREV_EN
    if (!is_pow2(DEPTH)) begin : g_depth_chk
        $error("stp_index_map: bit-reversed ordering needs a power-of-two DEPTH");
    end

    always_comb begin
        slot = '0;
        for (int b = 0; b < IDX_W; b++) begin
            slot[b] = idx[IDX_W-1-b];
        end
    end
`else
    assign slot = idx;
`endif

endmodule

// File: rtl/stp_frame_buffer.sv
// Serial-to-parallel frame buffer: collects DEPTH words and presents them as one held frame.
// Word ordering is natural, or bit-reversed when STP_BITREV_EN is defined (see stp_index_map).
module stp_frame_buffer
    import stp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             it_cnt_strobe,
    input  logic [DATA_W-1:0]                serial_in,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [DEPTH-1:0][DATA_W-1:0]     data_par,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [$clog2(DEPTH+1)-1:0]       fill_count,
    output logic                             overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > 256) begin : g_range_chk
        $error("stp_frame_buffer: DEPTH must be within 2..256");
    end

    in_state_e                       in_state_q, in_state_d;
    out_state_e                      out_state_q, out_state_d;
    logic [CNT_W-1:0]                fill_count_q, fill_count_d;
    logic                            overflow_q, overflow_d;
    logic [DEPTH-1:0][DATA_W-1:0]    shadow_q, shadow_d;
    logic [DEPTH-1:0][DATA_W-1:0]    data_par_q, data_par_d;

    logic [IDX_W-1:0]                slot;
    logic                            accept;
    logic                            completes;

    stp_index_map #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_index_map (
        .idx  (fill_count_q[IDX_W-1:0]),
        .slot (slot)
    );

    // Only the final word of a frame can stall, and only while the held frame is not being taken.
    assign in_ready  = !((in_state_q == IN_LAST) && (out_state_q == OUT_FULL) && !frame_ready);
    assign accept    = it_cnt_strobe && in_ready && !flush;
    assign completes = accept && (in_state_q == IN_LAST);

    always_comb begin
        fill_count_d = fill_count_q;
        overflow_d   = overflow_q;
        shadow_d     = shadow_q;
        data_par_d   = data_par_q;
        out_state_d  = out_state_q;

        if (flush) begin
            fill_count_d = '0;
            overflow_d   = 1'b0;
        end else if (it_cnt_strobe && !in_ready) begin
            overflow_d = 1'b1;
        end else if (accept) begin
            if (completes) begin
                fill_count_d     = '0;
                data_par_d       = shadow_q;
                data_par_d[slot] = serial_in;
            end else begin
                fill_count_d   = fill_count_q + CNT_W'(1);
                shadow_d[slot] = serial_in;
            end
        end

        // A completing frame wins over consumption so back-to-back frames have no bubble.
        if (completes) begin
            out_state_d = OUT_FULL;
        end else if ((out_state_q == OUT_FULL) && frame_ready) begin
            out_state_d = OUT_EMPTY;
        end

        in_state_d = (fill_count_d == LAST_CNT) ? IN_LAST : IN_FILL;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_state_q   <= IN_FILL;
            out_state_q  <= OUT_EMPTY;
            fill_count_q <= '0;
            overflow_q   <= 1'b0;
            shadow_q     <= '0;
            data_par_q   <= '0;
        end else begin
            in_state_q   <= in_state_d;
            out_state_q  <= out_state_d;
            fill_count_q <= fill_count_d;
            overflow_q   <= overflow_d;
            shadow_q     <= shadow_d;
            data_par_q   <= data_par_d;
        end
    end

    assign data_par    = data_par_q;
    assign frame_valid = (out_state_q == OUT_FULL);
    assign fill_count  = fill_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_stp_frame_buffer.sv
// Directed bench for stp_frame_buffer with a queue-based frame model checked every cycle.
// With STP_BITREV_EN defined it runs at DEPTH=8 and checks bit-reversed ordering.
module tb_stp_frame_buffer;
    import stp_pkg::*;

`ifdef STP_BITREV_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 48;
`endif
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);

    logic                         clk = 1'b0;
    logic                         n_rst = 1'b0;
    logic                         it_cnt_strobe = 1'b0;
    logic                         flush = 1'b0;
    logic                         frame_ready = 1'b0;
    logic [DATA_W-1:0]            serial_in = '0;
    logic                         in_ready;
    logic                         frame_valid;
    logic                         overflow;
    logic [DEPTH-1:0][DATA_W-1:0] data_par;
    logic [CNT_W-1:0]             fill_count;

    stp_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .it_cnt_strobe (it_cnt_strobe),
        .serial_in     (serial_in),
        .in_ready      (in_ready),
        .flush         (flush),
        .data_par      (data_par),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .fill_count    (fill_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Model state: words of the partial frame in arrival order, and the held frame.
    logic [DATA_W-1:0] part[$];
    logic [DATA_W-1:0] m_par[DEPTH];
    bit                m_valid;
    bit                m_ovf;
    int                n_pass = 0;
    int                n_total = 0;

    function automatic int slot_of(input int k);
`ifdef STP_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < IDX_W; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (IDX_W - 1 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    function automatic bit m_in_ready();
        return !((part.size() == DEPTH - 1) && m_valid && !frame_ready);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_clear();
        part.delete();
        m_valid = 0;
        m_ovf   = 0;
        for (int i = 0; i < DEPTH; i++) m_par[i] = '0;
    endtask

    task automatic model_edge();
        bit rdy;
        bit take;
        rdy  = m_in_ready();
        take = m_valid && frame_ready;
        if (flush) begin
            part.delete();
            m_ovf = 0;
        end else if (it_cnt_strobe && !rdy) begin
            m_ovf = 1;
        end else if (it_cnt_strobe) begin
            part.push_back(serial_in);
            if (part.size() == DEPTH) begin
                for (int k = 0; k < DEPTH; k++) m_par[slot_of(k)] = part[k];
                part.delete();
                m_valid = 1;
                take    = 0;
            end
        end
        if (take) m_valid = 0;
    endtask

    task automatic compare_all();
        int bad;
        bad = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (data_par[i] !== m_par[i]) bad = i;
        end
        check("fill_count", fill_count, part.size());
        check("frame_valid", frame_valid, m_valid);
        check("overflow", overflow, m_ovf);
        check($sformatf("data_par[%0d]", bad), data_par[bad], m_par[bad]);
    endtask

    task automatic step(input bit s, input int d, input bit f, input bit r);
        @(negedge clk);
        it_cnt_strobe = s;
        serial_in     = DATA_W'(d);
        flush         = f;
        frame_ready   = r;
        #1;
        check("in_ready", in_ready, m_in_ready());
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        n_rst         = 1'b0;
        it_cnt_strobe = 1'b0;
        flush         = 1'b0;
        frame_ready   = 1'b0;
        #1;
        model_clear();
        check("rst_fill_count", fill_count, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data_par_or", |data_par, 0);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

`ifdef STP_BITREV_EN
    int br_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`endif

    initial begin
        model_clear();
        apply_reset();

`ifdef STP_BITREV_EN
        for (int i = 0; i < 8; i++) step(1, i, 0, 0);
        check("br_frame_valid", frame_valid, 1);
        for (int i = 0; i < 8; i++) check($sformatf("br_data_par[%0d]", i), data_par[i], br_exp[i]);
        // Second frame completes on the consume edge, then an overflow attempt on a third.
        for (int i = 0; i < 7; i++) step(1, 20 + i, 0, 0);
        step(1, 27, 0, 1);
        check("br2_data_par[1]", data_par[1], 24);
        for (int i = 0; i < 8; i++) step(1, 40 + i, 0, 0);
        check("br_overflow", overflow, 1);
        check("br_data_par[4]", data_par[4], 21);
`else
        // Frame 1 with consumer stalled.
        for (int i = 0; i < 48; i++) step(1, i, 0, 0);
        check("f1_frame_valid", frame_valid, 1);
        check("f1_fill_count", fill_count, 0);
        check("f1_data_par[0]", data_par[0], 0);
        check("f1_data_par[13]", data_par[13], 13);
        check("f1_data_par[47]", data_par[47], 47);

        // Stall: 48th word dropped, overflow sticky.
        for (int i = 0; i < 48; i++) step(1, 200 + i, 0, 0);
        check("ovf_overflow", overflow, 1);
        check("ovf_fill_count", fill_count, 47);
        check("ovf_in_ready", in_ready, 0);
        check("ovf_data_par[47]", data_par[47], 47);

        step(0, 0, 1, 0);
        check("flush_overflow", overflow, 0);
        check("flush_fill_count", fill_count, 0);

        // Frame 2 completes on the consume edge: no bubble.
        for (int i = 0; i < 47; i++) step(1, 100 + i, 0, 0);
        step(1, 147, 0, 1);
        check("f2_frame_valid", frame_valid, 1);
        check("f2_data_par[0]", data_par[0], 100);
        check("f2_data_par[47]", data_par[47], 147);
        step(0, 0, 0, 1);
        check("f2_consumed", frame_valid, 0);

        // Partial frame, then flush together with a strobe.
        for (int i = 0; i < 20; i++) step(1, 300 + i, 0, 0);
        check("part_fill_count", fill_count, 20);
        check("part_data_par[0]", data_par[0], 100);
        step(1, 999, 1, 0);
        check("fls_fill_count", fill_count, 0);
        check("fls_overflow", overflow, 0);
        for (int i = 0; i < 48; i++) step(1, 400 + i, 0, 0);
        check("f3_data_par[0]", data_par[0], 400);
        check("f3_data_par[20]", data_par[20], 420);

        // Reset mid-frame with a held frame still present.
        for (int i = 0; i < 30; i++) step(1, 500 + i, 0, 0);
        check("mid_fill_count", fill_count, 30);
        apply_reset();
        for (int i = 0; i < 48; i++) step(1, 600 + i, 0, 0);
        check("f4_data_par[0]", data_par[0], 600);
        check("f4_data_par[47]", data_par[47], 647);
        check("f4_frame_valid", frame_valid, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stp_frame_buffer.md
STP_FRAME_BUFFER -- requirements
Module: stp_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of one serial word.
REQ-002 SHALL have parameter DEPTH, default 48, words per frame; legal range 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port it_cnt_strobe  input  1  active-high; a word is offered on serial_in this cycle.
REQ-006 SHALL have port serial_in  input  DATA_W  serial word.
REQ-007 SHALL have port in_ready  output  1  high when an offered word will be accepted.
REQ-008 SHALL have port flush  input  1  synchronous discard of the partial frame and the overflow flag.
REQ-009 SHALL have port data_par  output  DEPTH x DATA_W  held parallel frame.
REQ-010 SHALL have port frame_valid  output  1  data_par holds an unconsumed frame.
REQ-011 SHALL have port frame_ready  input  1  consumer takes the frame when it is high together with frame_valid.
REQ-012 SHALL have port fill_count  output  $clog2(DEPTH+1)  words accepted in the current partial frame.
REQ-013 SHALL have port overflow  output  1  sticky; set when a word is offered while in_ready is low.

Function
REQ-014 SHALL accept a word on an edge where it_cnt_strobe=1, in_ready=1 and flush=0.
REQ-015 SHALL place the k-th accepted word of a frame (k=0 first) at data_par[k] (natural order).
REQ-016 SHALL increment fill_count by 1 per accepted word; when the DEPTH-th word is accepted, fill_count SHALL wrap to 0 on that edge.
REQ-017 SHALL load all DEPTH words into the output register on the edge that accepts the DEPTH-th word; frame_valid SHALL be high from that edge (latency 0 cycles after the final acceptance edge).
REQ-018 SHALL hold data_par and frame_valid stable while frame_valid=1 and frame_ready=0.
REQ-019 SHALL clear frame_valid on an edge where frame_valid=1 and frame_ready=1, unless a new frame completes on the same edge; in that case frame_valid SHALL stay high with the new frame loaded (back-to-back, no bubble).
REQ-020 SHALL drive in_ready low only when fill_count=DEPTH-1, frame_valid=1 and frame_ready=0; otherwise high. in_ready MAY depend combinationally on frame_ready.
REQ-021 SHALL set overflow on an edge where it_cnt_strobe=1 and in_ready=0; the word SHALL be dropped and fill_count unchanged.
REQ-022 SHALL, on flush=1, set fill_count to 0 and clear overflow; frame_valid/data_par are unaffected. flush together with strobe SHALL drop the word without setting overflow.
REQ-023 SHALL leave data_par unchanged when no frame completes; words of a partial frame SHALL not appear on data_par.
REQ-024 SHALL treat the input side as two states, FILL (fill_count<DEPTH-1) and LAST (fill_count=DEPTH-1). The output side SHALL have two states, EMPTY and FULL (frame_valid).

Reset
REQ-025 SHALL, while n_rst=0, force fill_count=0, frame_valid=0, overflow=0 and data_par all zeros, regardless of clk.
REQ-026 SHALL discard any partial or held frame on reset mid-operation; the first frame after reset SHALL start at word index 0.

Configuration
REQ-027 SHALL, when macro STP_BITREV_EN is defined, place the k-th word at data_par[bitrev(k)] over $clog2(DEPTH) bits, for FFT input ordering; DEPTH SHALL then be a power of two, otherwise elaboration SHALL fail.
REQ-028 SHALL, without STP_BITREV_EN, use natural order per REQ-015 and impose no power-of-two restriction.

Structure
REQ-029 SHALL take DATA_W/DEPTH defaults, the input state enum (FILL, LAST) and the output state enum (EMPTY, FULL) from shared package stp_pkg.
REQ-030 SHALL contain one sub-module, stp_index_map, that maps write index k to a slot (identity, or bit reversal under STP_BITREV_EN).

Verification
REQ-031 Bench SHALL strobe words 0..47 consecutively with frame_ready=0 -> frame_valid=1 after the 48th edge, data_par[i]=i, fill_count=0.
REQ-032 Bench SHALL hold frame_ready=0 and strobe 48 more words -> in_ready=0 at fill_count=47, the 48th word dropped, overflow=1, data_par still 0..47.
REQ-033 Bench SHALL pulse frame_ready on the same edge as the final word of frame 2 (values 100..147) -> frame_valid stays 1, data_par[i]=100+i.
REQ-034 Bench SHALL strobe 20 words, then flush with a strobe in the same cycle -> fill_count=0, overflow=0, next frame starts at data_par[0].
REQ-035 Bench SHALL assert n_rst=0 mid-frame at fill_count=30 -> all outputs zero immediately; a following full frame is loaded correctly.
REQ-036 Bench SHALL, with STP_BITREV_EN and DEPTH=8, strobe words 0..7 -> data_par = {0,4,2,6,1,5,3,7} at indices 0..7.
